// File: rtl/flappy_pixel_if.sv
// Pixel-stage bus: sync-generator counters and flap button toward the game logic,
// colour and game status back out.
interface flappy_pixel_if;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       flap;
    logic [7:0] rgb;
    logic [1:0] game_state;
    logic [7:0] score;

    modport master (
        output hCount, vCount, bright, flap,
        input  rgb, game_state, score
    );

    modport slave (
        input  hCount, vCount, bright, flap,
        output rgb, game_state, score
    );
endinterface

// File: rtl/flappy_pixel_gen.sv
// Flappy-bird game state (physics, pipe, collision, score, FSM) and RRRGGGBB pixel colour.
// Optional random pipe gap: define FLAPPY_RANDOM_GAP_EN.
module flappy_pixel_gen #(
    parameter int BIRD_X     = 160,
    parameter int BIRD_SIZE  = 16,
    parameter int GRAVITY    = 1,
    parameter int FLAP_V     = 8,
    parameter int VMAX       = 10,
    parameter int PIPE_W     = 48,
    parameter int GAP_H      = 120,
    parameter int PIPE_SPEED = 2,
    parameter int GAP_FIXED  = 180
) (
    input  logic          clk,
    input  logic          rst_n,
    flappy_pixel_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam logic signed [10:0] P_BIRD_X     = 11'(BIRD_X);
    localparam logic signed [10:0] P_BIRD_SIZE  = 11'(BIRD_SIZE);
    localparam logic signed [10:0] P_PIPE_W     = 11'(PIPE_W);
    localparam logic signed [10:0] P_GAP_H      = 11'(GAP_H);
    localparam logic signed [10:0] P_PIPE_SPEED = 11'(PIPE_SPEED);
    localparam logic signed [10:0] P_GAP_FIXED  = 11'(GAP_FIXED);
    localparam logic signed [7:0]  P_GRAVITY    = 8'(GRAVITY);
    localparam logic signed [7:0]  P_FLAP_VEL   = -8'(FLAP_V);
    localparam logic signed [7:0]  P_VMAX       = 8'(VMAX);
    localparam logic signed [10:0] P_BIRD_Y0    = 11'sd232;
    localparam logic signed [10:0] P_PIPE_X0    = 11'sd640;
    localparam logic signed [10:0] P_SCREEN_H   = 11'sd480;
    localparam logic [4:0]         P_DEAD_HOLD  = 5'd30;
    localparam logic [9:0]         P_TICK_LINE  = 10'd516;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'h1F) ? v : v + 5'd1;
    endfunction

    function automatic logic signed [10:0] sext8(input logic signed [7:0] v);
        return $signed({{3{v[7]}}, v});
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_at_line;
    logic                  w_tick;
    logic                  r_flap_s1;
    logic                  r_flap_s2;
    logic                  r_flap_s3;
    logic                  w_flap_edge;
    logic                  r_flap_pend;
    logic signed [10:0]    r_bird_y;
    logic signed [7:0]     r_vel;
    logic signed [10:0]    r_pipe_x;
    logic signed [10:0]    r_gap_top;
    logic [7:0]            r_score;
    logic [4:0]            r_dead_cnt;
    logic [7:0]            r_rgb;

    logic signed [7:0]     w_vel_inc;
    logic signed [7:0]     w_vel_play;
    logic signed [10:0]    w_bird_play;
    logic signed [10:0]    w_pipe_mv;
    logic                  w_respawn;
    logic signed [10:0]    w_pipe_play;
    logic signed [10:0]    w_gap_new;
    logic signed [10:0]    w_gap_play;
    logic [7:0]            w_score_play;
    logic                  w_hit_edge;
    logic                  w_x_ovl;
    logic                  w_out_gap;
    logic                  w_collide;
    logic                  w_revive;

    logic signed [10:0]    w_bird_nxt;
    logic signed [7:0]     w_vel_nxt;
    logic signed [10:0]    w_pipe_nxt;
    logic signed [10:0]    w_gap_nxt;
    logic [7:0]            w_score_nxt;
    logic [4:0]            w_dead_cnt_nxt;

    logic signed [10:0]    w_sx;
    logic signed [10:0]    w_sy;
    logic                  w_bird_pix;
    logic                  w_pipe_pix;
    logic [7:0]            w_rgb_nxt;

    assign w_tick      = (bus.vCount == P_TICK_LINE) && !r_at_line;
    assign w_flap_edge = r_flap_s2 && !r_flap_s3;

    // Frame-tick edge detector and two-flop flap synchroniser with edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_at_line <= 1'b0;
            r_flap_s1 <= 1'b0;
            r_flap_s2 <= 1'b0;
            r_flap_s3 <= 1'b0;
        end else begin
            r_at_line <= (bus.vCount == P_TICK_LINE);
            r_flap_s1 <= bus.flap;
            r_flap_s2 <= r_flap_s1;
            r_flap_s3 <= r_flap_s2;
        end
    end

    // Pending flap; an edge landing on the tick itself survives into the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flap_pend <= 1'b0;
        end else if (w_tick) begin
            r_flap_pend <= w_flap_edge;
        end else if (w_flap_edge) begin
            r_flap_pend <= 1'b1;
        end else begin
            r_flap_pend <= r_flap_pend;
        end
    end

`ifdef FLAPPY_RANDOM_GAP_EN
    logic [7:0] r_lfsr;

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR for gap placement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_gap_new = 11'sd40 + $signed({3'b000, r_lfsr});
`else
    assign w_gap_new = P_GAP_FIXED;
`endif

    // One PLAY step: velocity, bird, pipe scroll and respawn, then collision on the new values
    always_comb begin
        w_vel_inc    = r_vel + P_GRAVITY;
        w_vel_play   = r_flap_pend ? P_FLAP_VEL : ((w_vel_inc > P_VMAX) ? P_VMAX : w_vel_inc);
        w_bird_play  = r_bird_y + sext8(w_vel_play);
        w_pipe_mv    = r_pipe_x - P_PIPE_SPEED;
        w_respawn    = (w_pipe_mv + P_PIPE_W) <= 11'sd0;
        w_pipe_play  = w_respawn ? P_PIPE_X0 : w_pipe_mv;
        w_gap_play   = w_respawn ? w_gap_new : r_gap_top;
        w_score_play = w_respawn ? sat_inc8(r_score) : r_score;
        w_hit_edge   = (w_bird_play <= 11'sd0) || ((w_bird_play + P_BIRD_SIZE) >= P_SCREEN_H);
        w_x_ovl      = (P_BIRD_X < (w_pipe_play + P_PIPE_W)) && (w_pipe_play < (P_BIRD_X + P_BIRD_SIZE));
        w_out_gap    = (w_bird_play < w_gap_play) ||
                       ((w_bird_play + P_BIRD_SIZE) > (w_gap_play + P_GAP_H));
        w_collide    = w_hit_edge || (w_x_ovl && w_out_gap);
        w_revive     = r_flap_pend && (r_dead_cnt >= P_DEAD_HOLD);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic, advanced only on the frame tick
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: w_state_nxt = r_flap_pend ? ST_PLAY : ST_IDLE;
                ST_PLAY: w_state_nxt = w_collide ? ST_DEAD : ST_PLAY;
                ST_DEAD: w_state_nxt = w_revive ? ST_IDLE : ST_DEAD;
                default: w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM outputs: next values of the game datapath
    always_comb begin
        w_bird_nxt     = r_bird_y;
        w_vel_nxt      = r_vel;
        w_pipe_nxt     = r_pipe_x;
        w_gap_nxt      = r_gap_top;
        w_score_nxt    = r_score;
        w_dead_cnt_nxt = r_dead_cnt;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_flap_pend) begin
                        w_bird_nxt  = w_bird_play;
                        w_vel_nxt   = w_vel_play;
                        w_pipe_nxt  = w_pipe_play;
                        w_gap_nxt   = w_gap_play;
                        w_score_nxt = w_score_play;
                    end else begin
                        w_bird_nxt  = P_BIRD_Y0;
                        w_vel_nxt   = 8'sd0;
                        w_pipe_nxt  = P_PIPE_X0;
                        w_score_nxt = 8'd0;
                    end
                    w_dead_cnt_nxt = 5'd0;
                end
                ST_PLAY: begin
                    w_bird_nxt     = w_bird_play;
                    w_vel_nxt      = w_vel_play;
                    w_pipe_nxt     = w_pipe_play;
                    w_gap_nxt      = w_gap_play;
                    w_score_nxt    = w_score_play;
                    w_dead_cnt_nxt = 5'd0;
                end
                ST_DEAD: begin
                    if (w_revive) begin
                        w_bird_nxt     = P_BIRD_Y0;
                        w_vel_nxt      = 8'sd0;
                        w_pipe_nxt     = P_PIPE_X0;
                        w_score_nxt    = 8'd0;
                        w_dead_cnt_nxt = 5'd0;
                    end else begin
                        w_dead_cnt_nxt = sat_inc5(r_dead_cnt);
                    end
                end
                default: begin
                    w_bird_nxt     = P_BIRD_Y0;
                    w_vel_nxt      = 8'sd0;
                    w_pipe_nxt     = P_PIPE_X0;
                    w_score_nxt    = 8'd0;
                    w_dead_cnt_nxt = 5'd0;
                end
            endcase
        end else begin
            w_dead_cnt_nxt = r_dead_cnt;
        end
    end

    // Game datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bird_y   <= P_BIRD_Y0;
            r_vel      <= 8'sd0;
            r_pipe_x   <= P_PIPE_X0;
            r_gap_top  <= P_GAP_FIXED;
            r_score    <= 8'd0;
            r_dead_cnt <= 5'd0;
        end else begin
            r_bird_y   <= w_bird_nxt;
            r_vel      <= w_vel_nxt;
            r_pipe_x   <= w_pipe_nxt;
            r_gap_top  <= w_gap_nxt;
            r_score    <= w_score_nxt;
            r_dead_cnt <= w_dead_cnt_nxt;
        end
    end

    // Pixel classification and colour priority
    always_comb begin
        w_sx       = $signed({1'b0, bus.hCount}) - 11'sd144;
        w_sy       = $signed({1'b0, bus.vCount}) - 11'sd35;
        w_bird_pix = (w_sx >= P_BIRD_X) && (w_sx < (P_BIRD_X + P_BIRD_SIZE)) &&
                     (w_sy >= r_bird_y) && (w_sy < (r_bird_y + P_BIRD_SIZE));
        w_pipe_pix = (w_sx >= r_pipe_x) && (w_sx < (r_pipe_x + P_PIPE_W)) &&
                     ((w_sy < r_gap_top) || (w_sy >= (r_gap_top + P_GAP_H)));
        if (!bus.bright) begin
            w_rgb_nxt = 8'h00;
        end else if (w_bird_pix) begin
            w_rgb_nxt = (r_state == ST_DEAD) ? 8'hE0 : 8'hFC;
        end else if (w_pipe_pix) begin
            w_rgb_nxt = 8'h1C;
        end else begin
            w_rgb_nxt = 8'h37;
        end
    end

    // Registered colour output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= 8'h00;
        end else begin
            r_rgb <= w_rgb_nxt;
        end
    end

    assign bus.rgb        = r_rgb;
    assign bus.game_state = r_state;
    assign bus.score      = r_score;

endmodule

// File: tb/tb_flappy_pixel_gen.sv
// Directed bench for flappy_pixel_gen: drives the sync counters directly so frames are a few clocks long.
module tb_flappy_pixel_gen;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       br;
        logic [7:0] exp_rgb;
    } pix_vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   dead_tick;
    pix_vec_t pv [15];

    flappy_pixel_if bus ();

    flappy_pixel_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        bus.hCount = 10'd0;
        bus.bright = 1'b0;
        bus.vCount = 10'd516;
        repeat (3) @(negedge clk);
        bus.vCount = 10'd0;
        @(negedge clk);
    endtask

    task automatic flap_pulse();
        @(negedge clk);
        bus.flap = 1'b1;
        repeat (4) @(negedge clk);
        bus.flap = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_pix(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            bus.hCount = pv[i].h;
            bus.vCount = pv[i].v;
            bus.bright = pv[i].br;
            @(negedge clk);
            check($sformatf("pix%0d", i), int'(bus.rgb), int'(pv[i].exp_rgb));
        end
        @(negedge clk);
        bus.vCount = 10'd0;
        bus.bright = 1'b0;
    endtask

    initial begin
        // idle scene, bird at y=232
        pv[0]  = '{10'd309, 10'd275, 1'b1, 8'hFC};
        pv[1]  = '{10'd154, 10'd45,  1'b1, 8'h37};
        pv[2]  = '{10'd309, 10'd275, 1'b0, 8'h00};
        pv[3]  = '{10'd319, 10'd282, 1'b1, 8'hFC};
        pv[4]  = '{10'd320, 10'd282, 1'b1, 8'h37};
        pv[5]  = '{10'd303, 10'd275, 1'b1, 8'h37};
        pv[6]  = '{10'd309, 10'd266, 1'b1, 8'h37};
        pv[7]  = '{10'd309, 10'd283, 1'b1, 8'h37};
        // dead bird at y=471
        pv[8]  = '{10'd309, 10'd510, 1'b1, 8'hE0};
        // pipe at x=440, gap 180..299
        pv[9]  = '{10'd594, 10'd135, 1'b1, 8'h1C};
        pv[10] = '{10'd594, 10'd235, 1'b1, 8'h37};
        pv[11] = '{10'd594, 10'd334, 1'b1, 8'h37};
        pv[12] = '{10'd594, 10'd335, 1'b1, 8'h1C};
        pv[13] = '{10'd631, 10'd135, 1'b1, 8'h1C};
        pv[14] = '{10'd632, 10'd135, 1'b1, 8'h37};

        bus.hCount = 10'd0;
        bus.vCount = 10'd0;
        bus.bright = 1'b0;
        bus.flap   = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rgb",   int'(bus.rgb), 0);
        check("rst_state", int'(bus.game_state), 0);
        check("rst_score", int'(bus.score), 0);
        check("rst_bird",  int'(dut.r_bird_y), 232);
        check("rst_vel",   int'(dut.r_vel), 0);
        check("rst_pipe",  int'(dut.r_pipe_x), 640);
        rst_n = 1'b1;

        for (int t = 0; t < 3; t++) do_tick();
        check("idle_state", int'(bus.game_state), 0);
        check("idle_bird",  int'(dut.r_bird_y), 232);
        apply_pix(0, 7);

        // flap rises on the same clock as the tick: must wait for the following tick
        @(negedge clk);
        bus.vCount = 10'd516;
        bus.flap   = 1'b1;
        repeat (3) @(negedge clk);
        bus.flap   = 1'b0;
        bus.vCount = 10'd0;
        repeat (2) @(negedge clk);
        check("coincide_state", int'(bus.game_state), 0);
        do_tick();
        check("t1_state", int'(bus.game_state), 1);
        check("t1_vel",   int'(dut.r_vel), -8);
        check("t1_bird",  int'(dut.r_bird_y), 224);
        do_tick();
        check("t2_vel",   int'(dut.r_vel), -7);
        check("t2_bird",  int'(dut.r_bird_y), 217);

        // free fall until the floor
        dead_tick = -1;
        for (int t = 3; t <= 60 && dead_tick < 0; t++) begin
            do_tick();
            if (t == 19) check("vel_vmax", int'(dut.r_vel), 10);
            if (t == 30) check("vel_hold", int'(dut.r_vel), 10);
            if (bus.game_state == 2'b10) dead_tick = t;
        end
        check("dead_tick", dead_tick, 41);
        check("dead_bird", int'(dut.r_bird_y), 471);
        apply_pix(8, 8);

        // dead hold-off: flaps at ticks 10 and 30 ignored, 31 revives
        for (int t = 1; t <= 31; t++) begin
            if (t == 10 || t == 30 || t == 31) flap_pulse();
            do_tick();
            if (t == 10) check("dead_t10", int'(bus.game_state), 2);
            if (t == 30) check("dead_t30", int'(bus.game_state), 2);
        end
        check("revive_state", int'(bus.game_state), 0);
        check("revive_score", int'(bus.score), 0);
        check("revive_bird",  int'(dut.r_bird_y), 232);
        check("revive_pipe",  int'(dut.r_pipe_x), 640);
        check("revive_vel",   int'(dut.r_vel), 0);

        // fly through the pipe with a flap every 17 ticks (zero net drift)
        for (int t = 1; t <= 344; t++) begin
            if ((t - 1) % 17 == 0) flap_pulse();
            do_tick();
            if (t == 100) begin
                check("pipe_t100", int'(dut.r_pipe_x), 440);
                apply_pix(9, 14);
            end
            if (t == 340) check("bird_t340", int'(dut.r_bird_y), 232);
            if (t == 343) begin
                check("pipe_t343",  int'(dut.r_pipe_x), -46);
                check("score_t343", int'(bus.score), 0);
            end
        end
        check("respawn_pipe",  int'(dut.r_pipe_x), 640);
        check("respawn_score", int'(bus.score), 1);
        check("respawn_state", int'(bus.game_state), 1);
        check("respawn_gap",   int'(dut.r_gap_top), 180);

        // asynchronous reset in the middle of a visible line
        @(negedge clk);
        bus.hCount = 10'd154;
        bus.vCount = 10'd45;
        bus.bright = 1'b1;
        @(negedge clk);
        check("pre_rst_rgb", int'(bus.rgb), 8'h37);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rgb",   int'(bus.rgb), 0);
        check("mid_rst_state", int'(bus.game_state), 0);
        check("mid_rst_score", int'(bus.score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.bright = 1'b0;
        do_tick();
        check("post_rst_state", int'(bus.game_state), 0);
        check("post_rst_bird",  int'(dut.r_bird_y), 232);
        check("post_rst_pipe",  int'(dut.r_pipe_x), 640);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
